// File: rtl/bridge_pkg.sv
// bridge_pkg: channel FSM state encoding, dead-time counter width and target helper
package bridge_pkg;
  localparam int DEAD_W = 8;
  typedef enum logic [1:0] {ST_OFF, ST_DEAD, ST_HIGH, ST_LOW} ch_state_e;
  function automatic ch_state_e target_of(input logic pwm, input logic brake);
    return (pwm && !brake) ? ST_HIGH : ST_LOW;
  endfunction
endpackage

// File: rtl/bridge_channel.sv
// bridge_channel: one half-bridge leg, break-before-make FSM with an 8-bit dead-time counter
module bridge_channel
  import bridge_pkg::*;
#(
  parameter int DEAD_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic kill,
  input  logic pwm,
  input  logic brake,
  output logic gate_hi,
  output logic gate_lo,
  output logic dead
);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
  ch_state_e state;
  ch_state_e target;
  logic [DEAD_W-1:0] cnt;
  assign target = target_of(pwm, brake);
  // State, counter and gate outputs all move together so gates are never both on
  always_ff @(posedge clk) begin
    if (!reset_n || kill) begin
      state   <= ST_OFF;
      cnt     <= '0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
      dead    <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          state <= ST_DEAD;
          cnt   <= DEAD_LOAD;
          dead  <= 1'b1;
        end
        ST_DEAD: begin
          if (cnt <= DEAD_W'(1)) begin
            state   <= target;
            cnt     <= '0;
            gate_hi <= target == ST_HIGH;
            gate_lo <= target == ST_LOW;
            dead    <= 1'b0;
          end else begin
            cnt <= cnt - DEAD_W'(1);
          end
        end
        default: begin
          if (target != state) begin
            state   <= ST_DEAD;
            cnt     <= DEAD_LOAD;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
            dead    <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/bridge_driver.sv
// bridge_driver: NUM_CH dead-time gate drivers plus Busy/FaultOut; BRIDGE_DRIVER_FAULT_LATCH_EN makes faults latch
module bridge_driver
  import bridge_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DEAD_CYCLES = 8
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [NUM_CH-1:0] PwmIn,
  input  logic [NUM_CH-1:0] Brake,
  input  logic              Enable,
  input  logic              Fault,
  output logic [NUM_CH-1:0] GateHi,
  output logic [NUM_CH-1:0] GateLo,
  output logic              Busy,
  output logic              FaultOut
);
  logic kill;
  logic fault_q;
  logic [NUM_CH-1:0] dead;
`ifdef BRIDGE_DRIVER_FAULT_LATCH_EN
  assign kill = !Enable || Fault || fault_q;
  // Fault latches until the enable is dropped with no fault present
  always_ff @(posedge Clk) begin
    if (!ResetN) fault_q <= 1'b0;
    else if (Fault) fault_q <= 1'b1;
    else if (!Enable) fault_q <= 1'b0;
  end
`else
  assign kill = !Enable || Fault;
  // Fault status simply follows the fault input one cycle later
  always_ff @(posedge Clk) begin
    fault_q <= ResetN && Fault;
  end
`endif
  assign FaultOut = fault_q;
  assign Busy     = |dead;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bridge_channel #(
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_ch (
      .clk    (Clk),
      .reset_n(ResetN),
      .kill   (kill),
      .pwm    (PwmIn[i]),
      .brake  (Brake[i]),
      .gate_hi(GateHi[i]),
      .gate_lo(GateLo[i]),
      .dead   (dead[i])
    );
  end
endmodule

// File: tb/tb_bridge_driver.sv
// tb_bridge_driver: scoreboard bench for bridge_driver at dead times 8 and 1, directed then random stimulus
module tb_bridge_driver;
  localparam int N  = 2;
  localparam int DA = 8;
  localparam int DB = 1;

  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  logic Enable = 1'b0;
  logic Fault = 1'b0;
  logic [N-1:0] PwmIn = '0;
  logic [N-1:0] Brake = '0;
  logic [N-1:0] hi_a, lo_a, hi_b, lo_b;
  logic busy_a, busy_b, fo_a, fo_b;

  typedef struct packed {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         fo;
  } obs_t;
  typedef obs_t [1:0] exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // reference: per unit/channel, powered flag, remaining dead cycles, driven side
  bit on[2][N];
  int dead_left[2][N];
  bit drv_hi[2][N];
  bit drv_lo[2][N];
  bit latched = 1'b0;

  always #5 Clk = ~Clk;

  bridge_driver #(.NUM_CH(N), .DEAD_CYCLES(DA)) dut_a (
    .Clk(Clk), .ResetN(ResetN), .PwmIn(PwmIn), .Brake(Brake), .Enable(Enable), .Fault(Fault),
    .GateHi(hi_a), .GateLo(lo_a), .Busy(busy_a), .FaultOut(fo_a)
  );
  bridge_driver #(.NUM_CH(N), .DEAD_CYCLES(DB)) dut_b (
    .Clk(Clk), .ResetN(ResetN), .PwmIn(PwmIn), .Brake(Brake), .Enable(Enable), .Fault(Fault),
    .GateHi(hi_b), .GateLo(lo_b), .Busy(busy_b), .FaultOut(fo_b)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // drive one cycle of inputs and queue what the outputs must be after the next edge
  task automatic step(input logic [N-1:0] p, input logic [N-1:0] b, input logic en, input logic f, input logic rn);
    exp_t e;
    bit kill;
    bit fo;
    bit want;
    int d;
    @(negedge Clk);
    PwmIn = p; Brake = b; Enable = en; Fault = f; ResetN = rn;
`ifdef BRIDGE_DRIVER_FAULT_LATCH_EN
    kill = !en || f || latched;
    latched = !rn ? 1'b0 : f ? 1'b1 : !en ? 1'b0 : latched;
    fo = latched;
`else
    kill = !en || f;
    fo = rn && f;
`endif
    for (int u = 0; u < 2; u++) begin
      d = (u == 0) ? DA : DB;
      e[u] = '0;
      e[u].fo = fo;
      for (int c = 0; c < N; c++) begin
        want = p[c] && !b[c];
        if (!rn || kill) begin
          on[u][c] = 1'b0; dead_left[u][c] = 0; drv_hi[u][c] = 1'b0; drv_lo[u][c] = 1'b0;
        end else if (!on[u][c]) begin
          on[u][c] = 1'b1; dead_left[u][c] = d;
        end else if (dead_left[u][c] > 0) begin
          dead_left[u][c]--;
          if (dead_left[u][c] == 0) begin
            drv_hi[u][c] = want; drv_lo[u][c] = !want;
          end
        end else if (drv_hi[u][c] != want) begin
          drv_hi[u][c] = 1'b0; drv_lo[u][c] = 1'b0; dead_left[u][c] = d;
        end
        e[u].hi[c] = drv_hi[u][c];
        e[u].lo[c] = drv_lo[u][c];
        if (dead_left[u][c] > 0) e[u].busy = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic [N-1:0] p, input logic [N-1:0] b, input logic en, input logic f);
    for (int k = 0; k < n; k++) step(p, b, en, f, 1'b1);
  endtask

  // monitor: compare every presented cycle against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hi_a", 8'(hi_a), 8'(e[0].hi));
        chk("lo_a", 8'(lo_a), 8'(e[0].lo));
        chk("busy_a", 8'(busy_a), 8'(e[0].busy));
        chk("fault_a", 8'(fo_a), 8'(e[0].fo));
        chk("hi_b", 8'(hi_b), 8'(e[1].hi));
        chk("lo_b", 8'(lo_b), 8'(e[1].lo));
        chk("busy_b", 8'(busy_b), 8'(e[1].busy));
        chk("fault_b", 8'(fo_b), 8'(e[1].fo));
        chk("overlap", 8'((hi_a & lo_a) | (hi_b & lo_b)), 8'd0);
      end
    end
  end

  initial begin
    logic [N-1:0] p, b;
    logic en, f, rn;
    for (int k = 0; k < 3; k++) step('0, '0, 1'b0, 1'b0, 1'b0);
    run(2, '0, '0, 1'b0, 1'b0);
    run(12, '0, '0, 1'b1, 1'b0);
    run(12, 2'b11, '0, 1'b1, 1'b0);
    run(12, 2'b00, '0, 1'b1, 1'b0);
    run(1, 2'b11, '0, 1'b1, 1'b0);
    run(1, 2'b00, '0, 1'b1, 1'b0);
    run(1, 2'b11, '0, 1'b1, 1'b0);
    run(12, 2'b00, '0, 1'b1, 1'b0);
    run(12, 2'b11, '0, 1'b1, 1'b0);
    run(12, 2'b11, 2'b10, 1'b1, 1'b0);
    run(12, 2'b11, '0, 1'b1, 1'b0);
    run(1, 2'b11, '0, 1'b1, 1'b1);
    run(4, 2'b11, '0, 1'b1, 1'b0);
    run(1, 2'b11, '0, 1'b0, 1'b0);
    run(12, 2'b11, '0, 1'b1, 1'b0);
    run(1, 2'b11, '0, 1'b1, 1'b1);
    run(1, 2'b11, '0, 1'b0, 1'b1);
    run(1, 2'b11, '0, 1'b0, 1'b0);
    run(4, 2'b01, '0, 1'b1, 1'b0);
    step(2'b01, '0, 1'b1, 1'b1, 1'b0);
    run(12, 2'b01, '0, 1'b1, 1'b0);
    step(2'b10, '0, 1'b1, 1'b0, 1'b0);
    run(3, 2'b10, '0, 1'b1, 1'b0);
    p = '0; b = '0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) p = N'($urandom);
      if ($urandom_range(0, 31) == 0) b = N'($urandom);
      en = $urandom_range(0, 49) != 0;
      f  = $urandom_range(0, 99) == 0;
      rn = $urandom_range(0, 199) != 0;
      step(p, b, en, f, rn);
    end
    @(negedge Clk);
    @(negedge Clk);
    chk("drain", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
